// File: rtl/oclib_pkg.sv
// Shared oclib types: AXI4 master channel structs (64/32-bit data), the arbiter
// FSM state encoding and the fixed single-beat attributes the arbiter drives.
package oclib_pkg;

    localparam int AxiIdWidth   = 4;
    localparam int AxiAddrWidth = 32;

    localparam logic [2:0]  AxiSizeWord   = 3'd2;
    localparam logic [1:0]  AxiBurstIncr  = 2'd1;
    localparam logic [3:0]  AxiCacheAttr  = 4'd3;
    localparam logic [2:0]  AxiProtAttr   = 3'd2;
    localparam logic [31:0] TimeoutPoison = 32'hDEAD_DEAD;

    typedef enum logic [2:0] {
        IDLE, WADDR, WRESP, RADDR, RRESP, DRAIN
    } arb_state_e;

    typedef struct packed {
        logic [AxiIdWidth-1:0]   id;
        logic [AxiAddrWidth-1:0] addr;
        logic [7:0]              len;
        logic [2:0]              size;
        logic [1:0]              burst;
        logic                    lock;
        logic [3:0]              cache;
        logic [2:0]              prot;
        logic [3:0]              qos;
        logic [3:0]              region;
    } axi4_ax_s;

    typedef struct packed {
        logic [AxiIdWidth-1:0] id;
        logic [1:0]            resp;
    } axi4_b_s;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  strb;
        logic        last;
    } axi4_w64_s;

    typedef struct packed {
        logic [AxiIdWidth-1:0] id;
        logic [63:0]           data;
        logic [1:0]            resp;
        logic                  last;
    } axi4_r64_s;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  strb;
        logic        last;
    } axi4_w32_s;

    typedef struct packed {
        logic [AxiIdWidth-1:0] id;
        logic [31:0]           data;
        logic [1:0]            resp;
        logic                  last;
    } axi4_r32_s;

    typedef struct packed {
        logic      awvalid;
        axi4_ax_s  aw;
        logic      wvalid;
        axi4_w64_s w;
        logic      bready;
        logic      arvalid;
        axi4_ax_s  ar;
        logic      rready;
    } axi4m_64_s;

    typedef struct packed {
        logic      awready;
        logic      wready;
        logic      bvalid;
        axi4_b_s   b;
        logic      arready;
        logic      rvalid;
        axi4_r64_s r;
    } axi4m_64_fb_s;

    typedef struct packed {
        logic      awvalid;
        axi4_ax_s  aw;
        logic      wvalid;
        axi4_w32_s w;
        logic      bready;
        logic      arvalid;
        axi4_ax_s  ar;
        logic      rready;
    } axi4m_32_s;

    typedef struct packed {
        logic      awready;
        logic      wready;
        logic      bvalid;
        axi4_b_s   b;
        logic      arready;
        logic      rvalid;
        axi4_r32_s r;
    } axi4m_32_fb_s;

endpackage

// File: rtl/oclib_arbiter_rr.sv
// Round-robin one-hot picker: first set request at or after ptr_i, wrapping.
module oclib_arbiter_rr #(
    parameter int NumReq = 4,
    localparam int PtrW  = (NumReq > 1) ? $clog2(NumReq) : 1
) (
    input  logic [NumReq-1:0] req_i,
    input  logic [PtrW-1:0]   ptr_i,
    output logic [NumReq-1:0] grant_o
);

    always_comb begin
        int         j;
        logic       found;
        logic [PtrW-1:0] sel;
        grant_o = '0;
        found   = 1'b0;
        j       = 0;
        sel     = '0;
        for (int i = 0; i < NumReq; i++) begin
            j = int'(ptr_i) + i;
            if (j >= NumReq) j = j - NumReq;
            sel = PtrW'(j);
            if (!found && req_i[sel]) begin
                grant_o[sel] = 1'b1;
                found        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/oclib_axim_arbiter.sv
// Round-robin share of one AXI4 master among NumReq single-beat CSR requesters.
// Define OCLIB_AXIM_ARBITER_TIMEOUT_EN to add the response watchdog and DRAIN state.
module oclib_axim_arbiter
    import oclib_pkg::*;
#(
    parameter int  NumReq        = 4,
    parameter int  AddressWidth  = 32,
    parameter type AxiType       = oclib_pkg::axi4m_64_s,
    parameter type AxiFbType     = oclib_pkg::axi4m_64_fb_s,
    parameter int  TimeoutCycles = 1024
) (
    input  logic                                    clock,
    input  logic                                    reset,
    input  logic [NumReq-1:0]                       reqValid,
    output logic [NumReq-1:0]                       reqReady,
    input  logic [NumReq-1:0]                       reqWrite,
    input  logic [NumReq-1:0][AddressWidth-1:0]     reqAddress,
    input  logic [NumReq-1:0][31:0]                 reqData,
    output logic [NumReq-1:0]                       respValid,
    output logic [31:0]                             respData,
    output logic                                    respError,
    output AxiType                                  axi,
    input  AxiFbType                                axiFb
);

    localparam int IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;
    // Data width follows the chosen AXI flavour; the 64-bit struct is the only wide one.
    localparam int DataWidth = ($bits(AxiType) == $bits(axi4m_64_s)) ? 64 : 32;
    localparam int StrbW     = DataWidth / 8;

    arb_state_e              state_q, state_d;
    logic [IdxW-1:0]         ptr_q, ptr_d, idx_q, idx_d, winIdx;
    logic [NumReq-1:0]       grant, idxOneHot;
    logic                    write_q, write_d, lane_q, lane_d;
    logic [AddressWidth-1:0] addr_q, addr_d;
    logic [31:0]             data_q, data_d;
    logic                    awDone_q, awDone_d, wDone_q, wDone_d;
    logic [NumReq-1:0]       respValid_q, respValid_d;
    logic [31:0]             respData_q, respData_d;
    logic                    respError_q, respError_d;
    logic                    awValid, wValid;
    logic [DataWidth-1:0]    wData, rShift;
    logic [StrbW-1:0]        wStrb;
    logic [31:0]             rdLane;

    oclib_arbiter_rr #(.NumReq(NumReq)) u_rr (
        .req_i   (reqValid),
        .ptr_i   (ptr_q),
        .grant_o (grant)
    );

    always_comb begin
        winIdx = '0;
        for (int i = 0; i < NumReq; i++)
            if (grant[i]) winIdx = IdxW'(i);
    end

    assign idxOneHot = NumReq'(1) << idx_q;
    assign awValid   = (state_q == WADDR) && !awDone_q;
    assign wValid    = (state_q == WADDR) && !wDone_q;
    assign wData     = DataWidth'(data_q) << {lane_q, 5'd0};
    assign wStrb     = StrbW'(4'hF) << {lane_q, 2'd0};
    assign rShift    = axiFb.r.data >> {lane_q, 5'd0};
    assign rdLane    = rShift[31:0];

    // Grant is only offered while idle and out of reset.
    assign reqReady  = (state_q == IDLE && reset) ? grant : '0;
    assign respValid = respValid_q;
    assign respData  = respData_q;
    assign respError = respError_q;

`ifdef OCLIB_AXIM_ARBITER_TIMEOUT_EN
    localparam int CntW = $clog2(TimeoutCycles + 1);
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            timeout;
    assign cnt_d   = (state_q == WRESP || state_q == RRESP) ? cnt_q + 1'b1 : '0;
    assign timeout = (cnt_q == CntW'(TimeoutCycles - 1));
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
`endif

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        idx_d       = idx_q;
        write_d     = write_q;
        addr_d      = addr_q;
        data_d      = data_q;
        lane_d      = lane_q;
        awDone_d    = awDone_q;
        wDone_d     = wDone_q;
        respValid_d = '0;
        respData_d  = respData_q;
        respError_d = respError_q;
        case (state_q)
            IDLE: if (|reqValid) begin
                idx_d    = winIdx;
                write_d  = reqWrite[winIdx];
                addr_d   = reqAddress[winIdx];
                data_d   = reqData[winIdx];
                lane_d   = (DataWidth == 64) ? reqAddress[winIdx][2] : 1'b0;
                ptr_d    = (int'(winIdx) == NumReq - 1) ? '0 : winIdx + 1'b1;
                awDone_d = 1'b0;
                wDone_d  = 1'b0;
                state_d  = reqWrite[winIdx] ? WADDR : RADDR;
            end
            WADDR: begin
                awDone_d = awDone_q | (awValid & axiFb.awready);
                wDone_d  = wDone_q  | (wValid  & axiFb.wready);
                if (awDone_d && wDone_d) state_d = WRESP;
            end
            WRESP: begin
                if (axiFb.bvalid) begin
                    respValid_d = idxOneHot;
                    respError_d = (axiFb.b.resp != 2'b00) || (axiFb.b.id != AxiIdWidth'(idx_q));
                    state_d     = IDLE;
                end
`ifdef OCLIB_AXIM_ARBITER_TIMEOUT_EN
                else if (timeout) begin
                    respValid_d = idxOneHot;
                    respError_d = 1'b1;
                    respData_d  = TimeoutPoison;
                    state_d     = DRAIN;
                end
`endif
            end
            RADDR: if (axiFb.arready) state_d = RRESP;
            RRESP: begin
                if (axiFb.rvalid) begin
                    respValid_d = idxOneHot;
                    respData_d  = rdLane;
                    respError_d = (axiFb.r.resp != 2'b00) || (axiFb.r.id != AxiIdWidth'(idx_q))
                                  || !axiFb.r.last;
                    state_d     = IDLE;
                end
`ifdef OCLIB_AXIM_ARBITER_TIMEOUT_EN
                else if (timeout) begin
                    respValid_d = idxOneHot;
                    respError_d = 1'b1;
                    respData_d  = TimeoutPoison;
                    state_d     = DRAIN;
                end
`endif
            end
`ifdef OCLIB_AXIM_ARBITER_TIMEOUT_EN
            // The late beat is swallowed; its requester was already answered.
            DRAIN: if (write_q ? axiFb.bvalid : axiFb.rvalid) state_d = IDLE;
`endif
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        axi = '0;
        if (state_q != IDLE) begin
            if (write_q) begin
                axi.aw.id    = AxiIdWidth'(idx_q);
                axi.aw.addr  = AxiAddrWidth'(addr_q);
                axi.aw.size  = AxiSizeWord;
                axi.aw.burst = AxiBurstIncr;
                axi.aw.cache = AxiCacheAttr;
                axi.aw.prot  = AxiProtAttr;
                axi.w.data   = wData;
                axi.w.strb   = wStrb;
                axi.w.last   = 1'b1;
            end else begin
                axi.ar.id    = AxiIdWidth'(idx_q);
                axi.ar.addr  = AxiAddrWidth'(addr_q);
                axi.ar.size  = AxiSizeWord;
                axi.ar.burst = AxiBurstIncr;
                axi.ar.cache = AxiCacheAttr;
                axi.ar.prot  = AxiProtAttr;
            end
        end
        axi.awvalid = awValid;
        axi.wvalid  = wValid;
        axi.arvalid = (state_q == RADDR);
        axi.bready  = (state_q == WRESP) || (state_q == DRAIN && write_q);
        axi.rready  = (state_q == RRESP) || (state_q == DRAIN && !write_q);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            idx_q       <= '0;
            write_q     <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            lane_q      <= 1'b0;
            awDone_q    <= 1'b0;
            wDone_q     <= 1'b0;
            respValid_q <= '0;
            respData_q  <= '0;
            respError_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            idx_q       <= idx_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            lane_q      <= lane_d;
            awDone_q    <= awDone_d;
            wDone_q     <= wDone_d;
            respValid_q <= respValid_d;
            respData_q  <= respData_d;
            respError_q <= respError_d;
        end
    end

endmodule

// File: tb/tb_oclib_axim_arbiter.sv
// Bench for oclib_axim_arbiter: bench-side AXI slave plus a round-robin/response model.
module tb_oclib_axim_arbiter;
    import oclib_pkg::*;

    localparam int N = 4;

    logic                 clock = 1'b0;
    logic                 reset;
    logic [N-1:0]         reqValid, reqReady, reqWrite, respValid;
    logic [N-1:0][31:0]   reqAddress, reqData;
    logic [31:0]          respData;
    logic                 respError;
    axi4m_64_s            axi;
    axi4m_64_fb_s         axiFb;

    int          nChk = 0, nFail = 0, ptrM = 0;
    logic [31:0] lastRd = '0;
    bit          refill = 0;

    oclib_axim_arbiter #(.NumReq(N)) dut (
        .clock(clock), .reset(reset), .reqValid(reqValid), .reqReady(reqReady),
        .reqWrite(reqWrite), .reqAddress(reqAddress), .reqData(reqData),
        .respValid(respValid), .respData(respData), .respError(respError),
        .axi(axi), .axiFb(axiFb)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nChk++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++)
            if (v[(p + k) % N]) return (p + k) % N;
        return 0;
    endfunction

    task automatic new_cmd(input int i);
        reqValid[i]   = 1'b1;
        reqWrite[i]   = 1'($urandom_range(0, 1));
        reqAddress[i] = $urandom & 32'hFFFF_FFFC;
        reqData[i]    = $urandom;
    endtask

    // Attribute bundle as an expected constant: len, size, burst, cache, prot, lock, qos, region.
    function automatic logic [63:0] attr_of(input axi4_ax_s a);
        return 64'({a.len, a.size, a.burst, a.cache, a.prot, a.lock, a.qos, a.region});
    endfunction
    localparam logic [63:0] AttrExp = 64'({8'd0, 3'd2, 2'd1, 4'd3, 3'd2, 1'b0, 4'd0, 4'd0});

    // Call at a negedge with the DUT idle and at least one reqValid set.
    task automatic run_txn(input int dA, input int dW, input int dR, input logic [1:0] rsp,
                           input bit idBad, input bit lastBad, input logic [63:0] rdat,
                           input bit rstMid);
        int w, n;
        bit wr, awd, wd, lane, errExp;
        logic [31:0] a, d;
        #1;
        w = rr_pick(reqValid, ptrM);
        chk("grant", 64'(reqReady), 64'(1) << w);
        ptrM = (w + 1) % N;
        wr = reqWrite[w]; a = reqAddress[w]; d = reqData[w]; lane = a[2];
        @(negedge clock);
        if (refill) new_cmd(w); else reqValid[w] = 1'b0;
        awd = 0; wd = !wr; n = 0;
        while (!(awd && wd) && n < 64) begin
            if (wr) begin
                chk("awvalid", axi.awvalid, !awd);
                chk("wvalid", axi.wvalid, !wd);
                chk("bready_early", axi.bready, 0);
                axiFb.awready = !awd && n >= dA;
                axiFb.wready  = !wd && n >= dW;
                if (axiFb.awready) begin
                    chk("aw_addr", axi.aw.addr, a);
                    chk("aw_id", axi.aw.id, w);
                    chk("aw_attr", attr_of(axi.aw), AttrExp);
                    awd = 1;
                end
                if (axiFb.wready) begin
                    chk("w_data", lane ? axi.w.data[63:32] : axi.w.data[31:0], d);
                    chk("w_strb", axi.w.strb, lane ? 8'hF0 : 8'h0F);
                    chk("w_last", axi.w.last, 1);
                    wd = 1;
                end
            end else begin
                chk("arvalid", axi.arvalid, 1);
                chk("rready_early", axi.rready, 0);
                axiFb.arready = n >= dA;
                if (axiFb.arready) begin
                    chk("ar_addr", axi.ar.addr, a);
                    chk("ar_id", axi.ar.id, w);
                    chk("ar_attr", attr_of(axi.ar), AttrExp);
                    awd = 1;
                end
            end
            @(negedge clock); n++;
        end
        axiFb.awready = 0; axiFb.wready = 0; axiFb.arready = 0;
        chk("addr_phase_bound", awd && wd, 1);
        chk("addr_valid_drop", {axi.awvalid, axi.wvalid, axi.arvalid}, 0);
        if (rstMid) begin
            chk("rready_pre_rst", axi.rready, 1);
            #2 reset = 1'b0;
            #1;
            chk("rst_axi_zero", |axi, 0);
            chk("rst_reqready", reqReady, 0);
            chk("rst_resp", {respValid, respError, respData}, 0);
            return;
        end
        for (int k = 0; k < dR; k++) begin
            chk(wr ? "bready" : "rready", wr ? axi.bready : axi.rready, 1);
            chk("resp_early", respValid, 0);
            @(negedge clock);
        end
        if (dR >= 1024) begin
            chk("to_pulse", 64'(respValid), 64'(1) << w);
            chk("to_err", respError, 1);
            chk("to_data", respData, 32'hDEAD_DEAD);
            lastRd = 32'hDEAD_DEAD;
            chk("drain_ready", wr ? axi.bready : axi.rready, 1);
            chk("drain_noreq", reqReady, 0);
        end
        chk(wr ? "bready" : "rready", wr ? axi.bready : axi.rready, 1);
        if (wr) begin
            axiFb.bvalid = 1; axiFb.b.id = idBad ? 4'(w ^ 1) : 4'(w); axiFb.b.resp = rsp;
        end else begin
            axiFb.rvalid = 1; axiFb.r.id = idBad ? 4'(w ^ 1) : 4'(w); axiFb.r.resp = rsp;
            axiFb.r.data = rdat; axiFb.r.last = !lastBad;
        end
        @(negedge clock);
        axiFb.bvalid = 0; axiFb.rvalid = 0;
        if (dR >= 1024) begin
            chk("drain_silent", respValid, 0);
            chk("drain_hold", respData, lastRd);
            return;
        end
        errExp = (rsp != 0) || idBad || (!wr && lastBad);
        if (!wr) lastRd = lane ? rdat[63:32] : rdat[31:0];
        chk("resp_vld", 64'(respValid), 64'(1) << w);
        chk("resp_err", respError, errExp);
        chk("resp_data", respData, lastRd);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=stuck exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; axiFb = '0;
        reqValid = '1; reqWrite = '0; reqAddress = '0; reqData = '0;
        repeat (3) @(negedge clock);
        chk("rst_reqready", reqReady, 0);
        chk("rst_axi", |axi, 0);
        chk("rst_resp", {respValid, respError, respData}, 0);
        reqValid = '0;
        reset = 1'b1;
        @(negedge clock);

        // Single write on the upper lane, then read back on requester 2.
        reqValid[0] = 1; reqWrite[0] = 1; reqAddress[0] = 32'h104; reqData[0] = 32'h1234_5678;
        run_txn(0, 0, 0, 0, 0, 0, '0, 0);
        reqValid[2] = 1; reqWrite[2] = 0; reqAddress[2] = 32'h100;
        run_txn(0, 0, 0, 0, 0, 0, 64'hAAAA_BBBB_CCCC_DDDD, 0);

        // Move the pointer to 0, then hold all four requesters for two rounds.
        new_cmd(3);
        run_txn(1, 2, 1, 0, 0, 0, {$urandom, $urandom}, 0);
        for (int i = 0; i < N; i++) new_cmd(i);
        refill = 1;
        for (int t = 0; t < 8; t++)
            run_txn($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2), 0, 0, 0,
                    {$urandom, $urandom}, 0);
        refill = 0;
        for (int t = 0; t < 4; t++) run_txn(0, 0, 0, 0, 0, 0, {$urandom, $urandom}, 0);

        // Handshake skew, write error response, read ID mismatch.
        new_cmd(1); reqWrite[1] = 1;
        run_txn(5, 0, 0, 0, 0, 0, '0, 0);
        new_cmd(1); reqWrite[1] = 1;
        run_txn(0, 0, 0, 2'd2, 0, 0, '0, 0);
        new_cmd(2); reqWrite[2] = 0;
        run_txn(0, 0, 0, 0, 1, 0, {$urandom, $urandom}, 0);

        // Reset mid-read, then requester 1 wins over 3 from pointer 0.
        new_cmd(1); reqWrite[1] = 0;
        run_txn(0, 0, 0, 0, 0, 0, '0, 1);
        @(negedge clock);
        new_cmd(1); new_cmd(3);
        @(negedge clock);
        reset = 1'b1; ptrM = 0; lastRd = '0;
        run_txn(0, 0, 0, 0, 0, 0, {$urandom, $urandom}, 0);
        run_txn(0, 0, 0, 0, 0, 0, {$urandom, $urandom}, 0);

        for (int t = 0; t < 80; t++) begin
            refill = 1'($urandom_range(0, 1));
            if (reqValid == '0) new_cmd($urandom_range(0, N - 1));
            run_txn($urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 3),
                    ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'd0,
                    ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
                    {$urandom, $urandom}, 0);
        end

`ifdef OCLIB_AXIM_ARBITER_TIMEOUT_EN
        refill = 0;
        while (reqValid != '0) run_txn(0, 0, 0, 0, 0, 0, {$urandom, $urandom}, 0);
        new_cmd(0); reqWrite[0] = 0;
        run_txn(0, 0, 1024, 0, 0, 0, {$urandom, $urandom}, 0);
        new_cmd(2);
        run_txn(0, 0, 0, 0, 0, 0, {$urandom, $urandom}, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", nChk, nFail);
        $finish;
    end

endmodule

// File: doc/oclib_axim_arbiter.md
Name: oclib_axim_arbiter

Overview:
Shares one AXI4 master port among NumReq simple 32-bit CSR-style requesters. Each requester issues a single-beat read or write on a valid/ready command interface. The block round-robin arbitrates, converts the winning command into a single-beat AXI4 transaction, and returns the response to that requester. One transaction is in flight at a time. Sits between CSR/DMA-control clients and the AXI fabric.

Parameters:
NumReq, 4, number of requesters (1..8; index becomes AXI ID)
AddressWidth, 32, requester and AXI address width
AxiType, oclib_pkg::axi4m_64_s, AXI4 master request struct (64- or 32-bit data)
AxiFbType, oclib_pkg::axi4m_64_fb_s, AXI4 master feedback struct
TimeoutCycles, 1024, response watchdog limit (used only with the optional feature)

Ports:
clock  input  1  clock
reset  input  1  asynchronous, active-low reset (asserted when 0)
reqValid  input  NumReq  command valid per requester
reqReady  output  NumReq  command accepted (one-hot, combinational in IDLE)
reqWrite  input  NumReq  1=write, 0=read
reqAddress  input  NumReq x AddressWidth  byte address (32-bit aligned)
reqData  input  NumReq x 32  write data
respValid  output  NumReq  one-cycle response pulse to the owning requester
respData  output  32  read data (shared; valid with respValid)
respError  output  1  nonzero resp, ID mismatch, missing last, or timeout
axi  output  AxiType  AXI4 master request channels
axiFb  input  AxiFbType  AXI4 ready/response channels

Behaviour:
- Reset (async assert, sync release): state=IDLE, rrPointer=0. All axi fields, reqReady, respValid, respData and respError are 0.
- States: IDLE -> WADDR -> WRESP -> IDLE (write); IDLE -> RADDR -> RRESP -> IDLE (read).
- IDLE arbitration:
  - Search for the first set reqValid starting at rrPointer, wrapping modulo NumReq.
  - Drive reqReady[winner]=1 in the same cycle and latch the command, index and lane.
  - Set rrPointer=(winner+1)%NumReq.
  - No reqValid set: stay in IDLE with pointer unchanged.
- AXI attributes: len=0, size=2, burst=1 (INCR), cache=3, prot=2, lock=0, id=winner index, all other fields 0.
- Lane selection: when DataWidth==64, lane=address bit 2 (byte offset 4). For 32-bit data the lane is always 0. Write data is placed in bytes lane*4..+3 with only those 4 strb bits set. Read data is taken from the same bytes.
- WADDR:
  - awvalid and wvalid (w.last=1) both assert in the cycle after accept.
  - Each drops independently on its own handshake.
  - Move to WRESP once both handshakes have completed (same cycle or different cycles).
- WRESP: bready=1. On bvalid, drive respValid[idx] for one cycle and respError=(b.resp!=0)|(b.id!=idx).
- RADDR: arvalid until arready, then RRESP.
- RRESP: rready=1. On rvalid, respData=selected lane and respError=(r.resp!=0)|(r.id!=idx)|!r.last. Pulse respValid[idx].
- Minimum latency: accept at cycle 0; address valid at cycle 1; ready at 1 -> response ready at 2; response at 2 -> respValid at 3. Back-to-back: the next accept can happen in the respValid cycle (state already IDLE).
- respData holds its last value between responses; respError is only meaningful with respValid.
- A requester dropping reqValid after acceptance has no effect. Commands are not retracted.
- Reset mid-transaction abandons it: no response is delivered, and the fabric is expected to be reset alongside.

Optional Feature:
OCLIB_AXIM_ARBITER_TIMEOUT_EN
- Defined:
  - A counter clears on entering WRESP/RRESP.
  - At TimeoutCycles without a response: pulse respValid[idx] with respError=1 and respData=32'hDEAD_DEAD.
  - Enter DRAIN, keeping bready/rready high, until the late response arrives. That response is discarded, then return to IDLE.
  - Address-phase stalls are not timed.
- Undefined: no counter and no DRAIN state. The block waits indefinitely for a response.

Decomposition:
- Package oclib_pkg gets:
  - typedef enum for the arbiter state (IDLE, WADDR, WRESP, RADDR, RRESP, DRAIN);
  - localparams for the fixed AXI attributes (cache=3, prot=2, size=2, burst=1);
  - the timeout poison value.
- Sub-module oclib_arbiter_rr: parameterised NumReq round-robin one-hot picker (request vector plus pointer in, one-hot grant out). Reusable elsewhere.

Test Plan:
- Single write: req0 write 0x00000104 data 0x12345678, 64-bit bus -> aw.addr=0x104, aw.id=0, w.strb=0xF0, w.data[63:32]=0x12345678, respValid[0] pulse, respError=0.
- Read back: req2 read 0x100, slave returns r.data=0xAAAA_BBBB_CCCC_DDDD, id=2 -> respData=0xCCCCDDDD, respValid[2]=1, respError=0.
- Fairness: all four requesters hold reqValid continuously for 8 transactions -> grant order 0,1,2,3,0,1,2,3, each respValid once per round.
- Handshake skew: awready delayed 5 cycles and wready given immediately -> wvalid drops after 1 cycle, awvalid after 5, bready asserts only after both handshakes.
- Error cases: slave returns b.resp=2; separately, r.id mismatch -> respError=1 on the matching respValid, and the block returns to IDLE.
- Async reset asserted while in RRESP -> all outputs 0 immediately. After release, req1 is granted first when requesters 1 and 3 are both valid, with rrPointer=0. With the feature defined: no response for 1024 cycles -> error pulse with 0xDEADDEAD, and the late r beat is drained.
